// File: rtl/mem_latency_responder.sv
// Memory responder for the cache backing-store interface: single-word read/write
// with a fixed completion latency, one-cycle ready pulse and address error flag.
module mem_latency_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_wen,
    input  logic        req_ren,
    output logic [31:0] req_rdata,
    output logic        req_ready,
    output logic        busy,
    output logic        err
);

    // state   | meaning
    // IDLE    | waiting for an armed request
    // WAIT    | latency countdown, enables ignored
    // DONE    | access completed, ready (and err) pulse this cycle
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_armed;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_op_wr;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_done;
    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic                  w_acc_wr;
    logic [31:0]           w_addr_hi;
    logic                  w_addr_err;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_accept = (r_state == ST_IDLE) && (req_wen || req_ren) && r_armed;

    // With LATENCY=1 the access happens on the accept edge itself, before the
    // request is latched, so it must be taken straight from the inputs.
    assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_acc_wr    = (r_state == ST_IDLE) ? req_wen   : r_op_wr;

    assign w_idx      = w_acc_addr[DEPTH_LOG2+1:2];
    assign w_addr_hi  = w_acc_addr >> (DEPTH_LOG2 + 2);
    assign w_addr_err = (w_acc_addr[1:0] != 2'b00) || (w_addr_hi != 32'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (CNT_INIT == 4'd0) begin
                        w_state_nxt  = ST_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = ST_DONE;
                    w_enter_done = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_armed <= 1'b1;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_op_wr <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_enter_done && w_addr_err;

            if (!req_wen && !req_ren) begin
                r_armed <= 1'b1;
            end else if (w_accept) begin
                r_armed <= 1'b0;
            end

            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_op_wr <= req_wen;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_done && !w_acc_wr) begin
                r_rdata <= w_addr_err ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Array is deliberately not reset; an aborted write never reaches this point.
    always_ff @(posedge clk) begin
        if (w_enter_done && w_acc_wr && !w_addr_err) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    assign req_rdata = r_rdata;
    assign req_ready = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Scoreboard bench for mem_latency_responder: directed requests push expected
// completions, a negedge monitor checks every ready pulse against them.
module tb_mem_latency_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_wen   = 1'b0;
    logic        req_ren   = 1'b0;
    logic [31:0] req_rdata;
    logic        req_ready;
    logic        busy;
    logic        err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q_exp[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_ready = 0;

    mem_latency_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wen   (req_wen),
        .req_ren   (req_ren),
        .req_rdata (req_rdata),
        .req_ready (req_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && req_ready === 1'b1) begin
            n_ready++;
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected no completion", cyc);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk({e.name, "_err"},   32'(err),  32'(e.err));
                chk({e.name, "_rdata"}, req_rdata, e.rdata);
                chk({e.name, "_cycle"}, 32'(cyc),  32'(e.cyc));
                chk({e.name, "_busy"},  32'(busy), 32'd1);
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wen, input logic ren, input logic [31:0] exp_rd,
                         input logic exp_err, input int hold);
        exp_t e;
        int   start;
        bit   got;
        @(negedge clk);
        req_addr  = addr;
        req_wdata = wdata;
        req_wen   = wen;
        req_ren   = ren;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + LAT;
        e.name  = nm;
        q_exp.push_back(e);
        start = n_ready;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_ready != start) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ready within 40 cycles, expected ready after %0d", nm, LAT);
            void'(q_exp.pop_front());
        end
        repeat (hold) @(negedge clk);
        req_wen = 1'b0;
        req_ren = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nr0;

        #1;
        chk("rst_rdata", req_rdata,        32'd0);
        chk("rst_ready", 32'(req_ready),   32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_err",   32'(err),         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // basic write then read
        issue("wr10",  32'h10, 32'hCAFEBABE, 1'b1, 1'b0, 32'h0,        1'b0, 0);
        issue("rd10",  32'h10, 32'h0,        1'b0, 1'b1, 32'hCAFEBABE, 1'b0, 0);
        issue("wr30",  32'h30, 32'h11112222, 1'b1, 1'b0, 32'hCAFEBABE, 1'b0, 0);

        // enable held long past ready: exactly one completion
        nr0 = n_ready;
        issue("rd10_hold", 32'h10, 32'h0, 1'b0, 1'b1, 32'hCAFEBABE, 1'b0, 6);
        chk("hold_busy_after", 32'(busy), 32'd0);
        chk("hold_single_ready", 32'(n_ready - nr0), 32'd1);

        // both enables: write wins, rdata untouched by write completion
        issue("both20", 32'h20, 32'h12345678, 1'b1, 1'b1, 32'hCAFEBABE, 1'b0, 0);
        issue("rd20",   32'h20, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 0);

        // misaligned write errors and does not disturb the array
        issue("wr13_err", 32'h13, 32'hDEADBEEF, 1'b1, 1'b0, 32'h12345678, 1'b1, 0);
        issue("rd10_b",   32'h10, 32'h0,        1'b0, 1'b1, 32'hCAFEBABE, 1'b0, 0);

        // out-of-range read returns zero with err
        issue("rd1000_err", 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 0);
        issue("rd10_c",     32'h10,   32'h0, 1'b0, 1'b1, 32'hCAFEBABE, 1'b0, 0);

        // reset mid-transaction aborts the pending write
        @(negedge clk);
        req_addr  = 32'h30;
        req_wdata = 32'h55AA55AA;
        req_wen   = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_rdata", req_rdata,      32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_err",   32'(err),       32'd0);
        req_wen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        issue("rd30_after_abort", 32'h30, 32'h0, 1'b0, 1'b1, 32'h11112222, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
